// File: rtl/pause_overlay_if.sv
// Pixel-path bundle between the renderer, the pause overlay and the VGA output register.
interface pause_overlay_if #(
    parameter int RGB_W = 5
);
    logic             pause_btn;
    logic             frame_tick;
    logic             video_on;
    logic [10:0]      pixel_x;
    logic [10:0]      pixel_y;
    logic [RGB_W-1:0] game_rgb;
    logic [RGB_W-1:0] vga_rgb;
    logic             paused;

    modport master (
        output pause_btn, frame_tick, video_on, pixel_x, pixel_y, game_rgb,
        input  vga_rgb, paused
    );

    modport slave (
        input  pause_btn, frame_tick, video_on, pixel_x, pixel_y, game_rgb,
        output vga_rgb, paused
    );
endinterface

// File: rtl/pause_overlay.sv
// Pause-screen overlay: frame-aligned pause toggling, blinking two-bar symbol, optional dimming.
module pause_overlay #(
    parameter int               H_ACTIVE     = 640,
    parameter int               V_ACTIVE     = 480,
    parameter int               RGB_W        = 5,
    parameter int               CENTER_X     = 320,
    parameter int               CENTER_Y     = 240,
    parameter int               BAR_W        = 16,
    parameter int               BAR_H        = 80,
    parameter int               BAR_GAP      = 48,
    parameter logic [RGB_W-1:0] COLOR_FG     = 5'b10101,
    parameter int               BLINK_FRAMES = 30,
    parameter bit               DIM_EN       = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    pause_overlay_if.slave bus
);
    localparam int X_LEFT  = CENTER_X - BAR_GAP / 2 - BAR_W;
    localparam int X_RIGHT = CENTER_X + BAR_GAP / 2;
    localparam int Y_TOP   = CENTER_Y - BAR_H / 2;
    localparam int Y_BOT   = CENTER_Y + BAR_H / 2;

    if (X_LEFT < 0 || X_RIGHT + BAR_W > H_ACTIVE || Y_TOP < 0 || Y_BOT > V_ACTIVE) begin : g_bounds_err
        $error("pause_overlay: pause symbol does not fit inside the active area");
    end

    localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENTER  = 2'd1,
        ST_PAUSED = 2'd2,
        ST_EXIT   = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             btn_q_reg;
    logic             press;
    logic [CNT_W-1:0] blink_cnt_reg;
    logic             blink_on_reg;
    logic             paused_int;
    logic [1:0]       bar_hit;
    logic             y_hit;
    logic             hit;
    logic [RGB_W-1:0] rgb_reg, rgb_next;

    assign press = bus.pause_btn & ~btn_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
            btn_q_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            btn_q_reg <= bus.pause_btn;
        end
    end

    // A request only ever commits on a tick seen after it has been accepted.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_RUN:    if (press)          state_next = ST_ENTER;
            ST_ENTER:  if (bus.frame_tick) state_next = ST_PAUSED;
            ST_PAUSED: if (press)          state_next = ST_EXIT;
            ST_EXIT:   if (bus.frame_tick) state_next = ST_RUN;
            default:                       state_next = ST_RUN;
        endcase
    end

    always_comb begin
        paused_int = (state_reg == ST_PAUSED) || (state_reg == ST_EXIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (state_reg == ST_ENTER && bus.frame_tick) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (paused_int && bus.frame_tick && BLINK_FRAMES != 0) begin
            if (blink_cnt_reg == CNT_LAST) begin
                blink_cnt_reg <= '0;
                blink_on_reg  <= ~blink_on_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_bar
        localparam int X_LO = (gi == 0) ? X_LEFT : X_RIGHT;
        localparam int X_HI = X_LO + BAR_W;
        assign bar_hit[gi] = (bus.pixel_x >= 11'(X_LO)) && (bus.pixel_x < 11'(X_HI));
    end

    assign y_hit = (bus.pixel_y >= 11'(Y_TOP)) && (bus.pixel_y < 11'(Y_BOT));
    assign hit   = y_hit && (|bar_hit);

    always_comb begin
        rgb_next = bus.game_rgb;
        if (!bus.video_on) begin
            rgb_next = '0;
        end else if (paused_int && blink_on_reg && hit) begin
            rgb_next = COLOR_FG;
        end else if (paused_int && DIM_EN) begin
            rgb_next = bus.game_rgb >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign bus.vga_rgb = rgb_reg;
    assign bus.paused  = paused_int;
endmodule

// File: tb/tb_pause_overlay.sv
// Directed bench for pause_overlay: two instances (blink period 2 and no blink) fed identical stimulus.
module tb_pause_overlay;
    logic        clk;
    logic        rst;
    logic        btn;
    logic        tick;
    logic        von;
    logic [10:0] px;
    logic [10:0] py;
    logic [4:0]  g;
    bit          chk_en;

    int checks;
    int errors;

    pause_overlay_if #(.RGB_W(5)) ifa ();
    pause_overlay_if #(.RGB_W(5)) ifb ();

    assign ifa.pause_btn = btn;  assign ifb.pause_btn = btn;
    assign ifa.frame_tick = tick; assign ifb.frame_tick = tick;
    assign ifa.video_on = von;   assign ifb.video_on = von;
    assign ifa.pixel_x = px;     assign ifb.pixel_x = px;
    assign ifa.pixel_y = py;     assign ifb.pixel_y = py;
    assign ifa.game_rgb = g;     assign ifb.game_rgb = g;

    pause_overlay #(.BLINK_FRAMES(2)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    pause_overlay #(.BLINK_FRAMES(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pause state as "committed flag + pending request", blink from frame count.
    int         bf [2] = '{2, 0};
    bit         m_paused [2];
    bit         m_pend [2];
    int         m_n [2];
    bit         m_prev;
    logic [4:0] exp_rgb [2];
    bit         exp_paused [2];

    function automatic bit in_symbol(input int x, input int y);
        int cx, cy, l0, r0;
        cx = 320; cy = 240;
        l0 = cx - 48 / 2 - 16;
        r0 = cx + 48 / 2;
        if (y < cy - 80 / 2 || y >= cy + 80 / 2) return 1'b0;
        return ((x >= l0 && x < l0 + 16) || (x >= r0 && x < r0 + 16));
    endfunction

    always @(posedge clk) begin
        bit hit, vis, press;
        hit   = in_symbol(int'(px), int'(py));
        press = btn && !m_prev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_rgb[k]  = 5'd0;
                m_paused[k] = 1'b0;
                m_pend[k]   = 1'b0;
                m_n[k]      = 0;
            end else begin
                vis = (bf[k] == 0) || (((m_n[k] / (bf[k] == 0 ? 1 : bf[k])) % 2) == 0);
                if (!von)                          exp_rgb[k] = 5'd0;
                else if (m_paused[k] && vis && hit) exp_rgb[k] = 5'b10101;
                else if (m_paused[k])              exp_rgb[k] = g / 2;
                else                               exp_rgb[k] = g;
                if (m_pend[k]) begin
                    if (tick) begin
                        m_paused[k] = !m_paused[k];
                        m_pend[k]   = 1'b0;
                        m_n[k]      = 0;
                    end
                end else begin
                    if (m_paused[k] && tick) m_n[k] = m_n[k] + 1;
                    if (press) m_pend[k] = 1'b1;
                end
            end
            exp_paused[k] = m_paused[k];
        end
        m_prev = rst ? 1'b1 : btn;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 4;
            if (ifa.vga_rgb !== exp_rgb[0]) begin
                errors = errors + 1;
                $display("FAIL model_rgb_a t=%0t got %b want %b", $time, ifa.vga_rgb, exp_rgb[0]);
            end
            if (ifb.vga_rgb !== exp_rgb[1]) begin
                errors = errors + 1;
                $display("FAIL model_rgb_b t=%0t got %b want %b", $time, ifb.vga_rgb, exp_rgb[1]);
            end
            if (ifa.paused !== exp_paused[0]) begin
                errors = errors + 1;
                $display("FAIL model_paused_a t=%0t got %b want %b", $time, ifa.paused, exp_paused[0]);
            end
            if (ifb.paused !== exp_paused[1]) begin
                errors = errors + 1;
                $display("FAIL model_paused_b t=%0t got %b want %b", $time, ifb.paused, exp_paused[1]);
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %b want %b", name, act, exp);
        end else begin
            $display("check %s = %b ok", name, act);
        end
    endtask

    task automatic cyc(input bit b, input bit t, input bit v, input int x, input int y, input logic [4:0] c);
        btn = b; tick = t; von = v; px = 11'(x); py = 11'(y); g = c;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 100 + i, 120, 5'($urandom_range(0, 31)));
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        rst = 1'b1; btn = 1'b1; tick = 1'b0; von = 1'b1; px = '0; py = '0; g = '0;
        @(posedge clk); #2;
        chk_en = 1'b1;
        cyc(1, 0, 1, 100, 100, 5'h07);
        chk("reset_rgb", ifa.vga_rgb, 5'd0);
        chk("reset_paused", {4'd0, ifa.paused}, 5'd0);
        rst = 1'b0;

        // Button held through reset, three ticks: no press, plain pass-through.
        for (int i = 0; i < 6; i++) cyc(1, i % 2 == 1, 1, 100 + i, 100, 5'(3 * i + 1));
        chk("held_btn_paused", {4'd0, ifa.paused}, 5'd0);
        chk("passthrough", ifa.vga_rgb, 5'd16);

        // Press, commit 100 cycles later.
        cyc(0, 0, 1, 10, 10, 5'd1);
        cyc(1, 0, 1, 10, 10, 5'd2);
        idle(98);
        chk("enter_wait_paused", {4'd0, ifa.paused}, 5'd0);
        cyc(1, 1, 1, 100, 100, 5'd9);
        chk("commit_paused", {4'd0, ifa.paused}, 5'd1);
        chk("commit_cycle_undimmed", ifa.vga_rgb, 5'd9);
        cyc(1, 0, 1, 285, 240, 5'b00011);
        chk("sym_285_240", ifa.vga_rgb, 5'b10101);
        cyc(1, 0, 1, 320, 240, 5'b11110);
        chk("gap_320_240_dim", ifa.vga_rgb, 5'b01111);
        cyc(1, 0, 1, 285, 199, 5'b10110);
        chk("above_285_199_dim", ifa.vga_rgb, 5'b01011);
        cyc(1, 0, 1, 280, 200, 5'b00110);
        chk("corner_280_200", ifa.vga_rgb, 5'b10101);
        cyc(1, 0, 1, 296, 240, 5'b00110);
        chk("edge_296_240_dim", ifa.vga_rgb, 5'b00011);
        cyc(1, 0, 1, 359, 279, 5'b00110);
        chk("corner_359_279", ifa.vga_rgb, 5'b10101);
        cyc(1, 0, 1, 360, 240, 5'b01000);
        chk("edge_360_240_dim", ifa.vga_rgb, 5'b00100);

        // Blink with period 2: tick 0 was the commit.
        cyc(1, 1, 1, 100, 100, 5'd0);
        cyc(1, 0, 1, 350, 250, 5'b10100);
        chk("blink_t1_visible", ifa.vga_rgb, 5'b10101);
        cyc(1, 1, 1, 100, 100, 5'd0);
        cyc(1, 0, 1, 350, 250, 5'b10100);
        chk("blink_t2_hidden", ifa.vga_rgb, 5'b01010);
        chk("noblink_t2_visible", ifb.vga_rgb, 5'b10101);
        cyc(1, 1, 1, 100, 100, 5'd0);
        cyc(1, 0, 1, 350, 250, 5'b10100);
        chk("blink_t3_hidden", ifa.vga_rgb, 5'b01010);
        cyc(1, 1, 1, 100, 100, 5'd0);
        cyc(1, 0, 1, 350, 250, 5'b10100);
        chk("blink_t4_visible", ifa.vga_rgb, 5'b10101);

        // Press in PAUSED, then reset before the committing tick.
        cyc(0, 0, 1, 10, 10, 5'd3);
        cyc(1, 0, 1, 10, 10, 5'd3);
        chk("exit_pending_paused", {4'd0, ifa.paused}, 5'd1);
        rst = 1'b1;
        cyc(1, 0, 1, 320, 240, 5'b11110);
        chk("midreset_rgb", ifa.vga_rgb, 5'd0);
        chk("midreset_paused", {4'd0, ifa.paused}, 5'd0);
        rst = 1'b0;
        cyc(1, 0, 1, 320, 240, 5'b11110);
        chk("after_reset_undimmed", ifa.vga_rgb, 5'b11110);

        // Press coincident with a tick in RUN does not commit; a second press in ENTER is ignored.
        cyc(0, 0, 1, 10, 10, 5'd4);
        cyc(1, 1, 1, 10, 10, 5'd4);
        chk("coincident_not_committed", {4'd0, ifa.paused}, 5'd0);
        cyc(0, 0, 1, 10, 10, 5'd4);
        cyc(1, 0, 1, 10, 10, 5'd4);
        cyc(1, 1, 1, 10, 10, 5'd4);
        chk("enter_commit_next_tick", {4'd0, ifa.paused}, 5'd1);
        idle(3);
        chk("second_press_ignored", {4'd0, ifa.paused}, 5'd1);

        // Press coincident with the EXIT commit tick is ignored.
        cyc(0, 0, 1, 10, 10, 5'd5);
        cyc(1, 0, 1, 10, 10, 5'd5);
        cyc(0, 0, 1, 10, 10, 5'd5);
        cyc(1, 1, 1, 10, 10, 5'd5);
        chk("exit_commit", {4'd0, ifa.paused}, 5'd0);
        cyc(1, 1, 1, 10, 10, 5'd5);
        chk("exit_press_ignored", {4'd0, ifa.paused}, 5'd0);

        // Pause again; blanking and the no-blink instance.
        cyc(0, 0, 1, 10, 10, 5'd6);
        cyc(1, 0, 1, 10, 10, 5'd6);
        cyc(1, 1, 1, 10, 10, 5'd6);
        chk("repause", {4'd0, ifa.paused}, 5'd1);
        cyc(1, 0, 0, 290, 240, 5'b11111);
        chk("blank_symbol", ifa.vga_rgb, 5'd0);
        cyc(1, 0, 0, 700, 500, 5'b11111);
        chk("blank_offscreen", ifa.vga_rgb, 5'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 1, 290, 240, 5'(i));
            chk("noblink_tick", ifb.vga_rgb, 5'b10101);
        end
        cyc(1, 0, 1, 100, 100, 5'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
